// File: rtl/seq_detect_1011_pkg.sv
// Shared types and constants for the 1011 serial pattern detector.
// The detector state encoding and the pattern value live here.
package seq_detect_1011_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;

  // Each state names the longest pattern prefix that ends the sampled stream.
  function automatic state_t next_state(input state_t s, input logic d);
    state_t n;
    n = IDLE;
    case (s)
      IDLE:    n = d ? S1    : IDLE;
      S1:      n = d ? S1    : S10;
      S10:     n = d ? S101  : IDLE;
      S101:    n = d ? S1011 : S10;
      S1011:   n = d ? S1    : S10;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_detect_1011_sat_counter.sv
// Saturating up-counter with a registered all-ones flag.
// Once the count reaches all ones it holds until reset.
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] count_reg;
  logic             sat_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else if (inc && !sat_reg) begin
      count_reg <= count_reg + 1'b1;
      // Flag rises on the same edge that the count becomes all ones.
      sat_reg   <= (count_reg == (MAX_VAL - 1'b1));
    end
  end

  assign count = count_reg;
  assign sat   = sat_reg;

endmodule

// File: rtl/seq_detect_1011.sv
// Moore detector for the serial pattern 1011 with overlap, a saturating
// match counter and a four-bit history of sampled bits.
module seq_detect_1011
  import seq_detect_1011_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             D,
  input  logic             En,
  output logic             Match,
  output logic [CNT_W-1:0] Count,
  output logic             Sat,
  output logic [3:0]       Last
);

  state_t     state_reg;
  state_t     state_next;
  logic       match_reg;
  logic [3:0] last_reg;
  logic       hit;

  always_comb begin
    state_next = next_state(state_reg, D);
    // One increment per entry into the match state.
    hit        = En && (state_next == S1011) && (state_reg != S1011);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      match_reg <= 1'b0;
      last_reg  <= 4'b0000;
    end else if (En) begin
      state_reg <= state_next;
      match_reg <= (state_next == S1011);
      last_reg  <= {last_reg[2:0], D};
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_count (
    .Clk  (Clk),
    .Reset(Reset),
    .inc  (hit),
    .count(Count),
    .sat  (Sat)
  );

  assign Match = match_reg;
  assign Last  = last_reg;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Bench for seq_detect_1011: history-based reference model checked every
// cycle on two counter widths, plus directed scenarios with literal values.
module tb_seq_detect_1011;
  import seq_detect_1011_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic d   = 1'b0;
  logic en  = 1'b0;

  logic       match4, sat4, match2, sat2;
  logic [3:0] cnt4, last4, last2;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;

  // Model: the last four sampled bits and the number of times they formed the pattern.
  logic [3:0] m_last = 4'b0000;
  int         m_cnt  = 0;

  always #5 clk = ~clk;

  seq_detect_1011 dut4 (
    .Clk(clk), .Reset(rst), .D(d), .En(en),
    .Match(match4), .Count(cnt4), .Sat(sat4), .Last(last4)
  );

  seq_detect_1011 #(.CNT_W(2)) dut2 (
    .Clk(clk), .Reset(rst), .D(d), .En(en),
    .Match(match2), .Count(cnt2), .Sat(sat2), .Last(last2)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last <= 4'b0000;
      m_cnt  <= 0;
    end else if (en) begin
      m_last <= {m_last[2:0], d};
      if ({m_last[2:0], d} == PATTERN) m_cnt <= m_cnt + 1;
    end
  end

  function automatic int exp_count(input int w);
    int mx;
    mx = (1 << w) - 1;
    return (m_cnt > mx) ? mx : m_cnt;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_match4", match4, m_last == PATTERN);
    chk("model_count4", cnt4, exp_count(4));
    chk("model_sat4", sat4, exp_count(4) == 15);
    chk("model_last4", last4, m_last);
    chk("model_match2", match2, m_last == PATTERN);
    chk("model_count2", cnt2, exp_count(2));
    chk("model_sat2", sat2, exp_count(2) == 3);
    chk("model_last2", last2, m_last);
  end

  // Drive one sample, then return 1 time unit after the edge that took it.
  task automatic send(input logic dv, input logic ev);
    d  = dv;
    en = ev;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i], 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      d = ~d;
      chk("rst_match", match4, 0);
      chk("rst_count", cnt4, 0);
      chk("rst_sat", sat4, 0);
      chk("rst_last", last4, 4'b0000);
    end
    rst = 1'b0;

    // Basic detection 1,0,1,1 then 0
    send_bits(16'b101, 3);
    chk("basic_pre_match", match4, 0);
    send(1'b1, 1'b1);
    chk("basic_match", match4, 1);
    chk("basic_count", cnt4, 1);
    chk("basic_last", last4, 4'b1011);
    send(1'b0, 1'b1);
    chk("basic_drop", match4, 0);

    // Overlap 1011011
    pulse_reset();
    send_bits(16'b1011, 4);
    chk("ovl_match1", match4, 1);
    send(1'b0, 1'b1);
    chk("ovl_gap", match4, 0);
    send_bits(16'b11, 2);
    chk("ovl_match2", match4, 1);
    chk("ovl_count", cnt4, 2);

    // Enable gaps
    pulse_reset();
    send_bits(16'b10, 2);
    repeat (3) send(1'b1, 1'b0);
    chk("gap_hold_last", last4, 4'b0010);
    send(1'b1, 1'b1);
    chk("gap_pre_match", match4, 0);
    send(1'b1, 1'b1);
    chk("gap_match", match4, 1);
    chk("gap_count", cnt4, 1);
    repeat (2) send(1'b0, 1'b0);
    chk("gap_match_held", match4, 1);
    chk("gap_count_held", cnt4, 1);

    // Saturation on the 2-bit counter
    pulse_reset();
    send_bits(16'b1011011011, 10);
    chk("sat_count3", cnt2, 3);
    chk("sat_flag", sat2, 1);
    send_bits(16'b011, 3);
    chk("sat_match4th", match2, 1);
    chk("sat_count_held", cnt2, 3);
    chk("sat_wide_count", cnt4, 4);
    chk("sat_wide_flag", sat4, 0);

    // Mid-cycle reset after 1,0,1
    pulse_reset();
    send_bits(16'b101, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_last", last4, 4'b0000);
    chk("mid_rst_count", cnt4, 0);
    chk("mid_rst_match", match4, 0);
    rst = 1'b0;
    #1;
    send(1'b1, 1'b1);
    chk("post_rst_match", match4, 0);
    chk("post_rst_count", cnt4, 0);
    chk("post_rst_last", last4, 4'b0001);

    // Randomized stream with occasional resets
    pulse_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      send(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_1011.md
# seq_detect_1011

Serial bit-stream consumer placed directly downstream of the single-bit D flip-flop stage. It samples the registered serial bit on qualifying clock edges and runs a Moore FSM that detects the pattern 1011, overlaps included. It also keeps a saturating match counter and a 4-bit history of sampled bits for observation.

## Interface
- CNT_W, default 4: width of the match counter, minimum 2.

- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- D  in  1  serial data bit, sampled on the rising Clk edge when En=1.
- En  in  1  sample enable; with En=0 all state holds.
- Match  out  1  Moore output, high while the FSM is in state S1011.
- Count  out  CNT_W  number of detections, saturating at 2^CNT_W-1.
- Sat  out  1  high when Count is all ones.
- Last  out  4  last four sampled bits, newest in bit 0.

One clock. Reset is asynchronous and active-high.

## Operation
- FSM states: IDLE, S1, S10, S101, S1011. Transitions occur only on an edge with En=1.
  - IDLE: D=1 goes to S1; D=0 stays in IDLE.
  - S1: D=1 stays in S1; D=0 goes to S10.
  - S10: D=1 goes to S101; D=0 goes to IDLE.
  - S101: D=1 goes to S1011; D=0 goes to S10.
  - S1011: D=1 goes to S1; D=0 goes to S10. This implements overlap.
- Match is (state == S1011), decoded from registered state only, so it has no combinational path from D or En.
- Count increments on each edge where the next state is S1011 and the current state is not. This means one increment per entry.
- At 2^CNT_W-1, Count holds and Sat=1. Only Reset clears Count.
- Last: on an edge with En=1, Last <= {Last[2:0], D}.
- En=0: state, Count and Last hold. Match stays high if already in S1011.
- Reset: state returns to IDLE. Match=0, Count=0, Sat=0, Last=4'b0000.

## Timing
- Latency: Match rises on the same edge that samples the 4th bit of the pattern. It is visible in the cycle after that edge.
- Match width:
  - With continuous En, Match is high for exactly one cycle per detection.
  - With En=0 while in S1011, Match stays high until the next sampling edge.
- Count updates on the same edge that Match rises. Sat updates on the same edge that Count reaches all ones.
- Back-to-back overlapped detections are at least 3 sampled bits apart, for example 1011011.
- Reset asserted between edges clears all outputs without waiting for Clk.
- After Reset deasserts, the first edge with En=1 samples from IDLE. Any earlier prefix is discarded.
- Reset deasserting coincident with a Clk edge: that edge is ignored, and sampling starts on the following edge.
- Saturation boundary: if an entry into S1011 occurs while Count is all ones, Match still pulses and Count is unchanged.

## Structure
- Shared package holds:
  - the state encoding constants, binary 3-bit: IDLE=0, S1=1, S10=2, S101=3, S1011=4;
  - the constant for the pattern value 4'b1011, used by the bench as a reference model.
- One sub-module, sat_counter, parameterised by width. Its ports are Clk, Reset, inc, count and sat. It is instantiated once for Count/Sat.
- The FSM and the Last shift register live in the top module.

## Test plan
- Reset held high for 3 edges with D toggling: Match=0, Count=0, Sat=0 and Last=0000 throughout.
- En=1, D stream 1,0,1,1:
  - Match=1 only in the cycle after edge 4;
  - Count=1 and Last=1011 after edge 4;
  - D=0 next gives Match=0.
- Overlap, En=1, D stream 1,0,1,1,0,1,1: Match pulses after edges 4 and 7, and Count=2.
- Enable gaps:
  - D stream 1,0, then En=0 for 3 cycles with D=1, then En=1 with D=1,1: Match rises after the last sampled bit, and Count=1.
  - Then En=0 for 2 cycles: Match stays 1, and Count stays 1.
- Saturation with CNT_W=2, stream 1011011011011 (4 detections): Count=3 and Sat=1 after the 3rd detection. At the 4th detection Match still pulses and Count stays 3.
- Reset pulse mid-cycle after receiving 1,0,1: outputs clear before the next edge. Then D=1 gives S1, not a match, and Count=0.
